sk6805_color_ctrl: RTL



---
 rtl/sk6805_pkg.sv | 32 +++
 rtl/sk6805_fade_chan.sv | 49 ++++
 rtl/sk6805_color_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sk6805_pkg.sv
// Shared types and constants for the SK6805 colour controller: FSM states,
// class-to-colour lookup and LED2 status colours.
package sk6805_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FADE   = 2'd1,
    HOLD   = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam logic [23:0] STATUS_OFF  = 24'h00_00_00;
  localparam logic [23:0] STATUS_BUSY = 24'h00_00_10;
  localparam logic [23:0] STATUS_HOLD = 24'h00_10_00;

  function automatic logic [23:0] class_rgb(input logic [2:0] cls);
    logic [23:0] rgb_s;
    case (cls)
      3'd0:    rgb_s = 24'h00_00_00;
      3'd1:    rgb_s = 24'hFF_00_00;
      3'd2:    rgb_s = 24'h00_FF_00;
      3'd3:    rgb_s = 24'h00_00_FF;
      3'd4:    rgb_s = 24'hFF_FF_00;
      3'd5:    rgb_s = 24'h00_FF_FF;
      3'd6:    rgb_s = 24'hFF_00_FF;
      3'd7:    rgb_s = 24'h40_40_40;
      default: rgb_s = 24'h00_00_00;
    endcase
    return rgb_s;
  endfunction

endpackage

// File: rtl/sk6805_fade_chan.sv
// One 8-bit colour channel that moves toward its target by at most STEP per
// tick, landing exactly on the target without overshoot or wrap.
module sk6805_fade_chan #(
  parameter int unsigned STEP = 4
) (
  input  logic       clk_10MHz,
  input  logic       Rst,
  input  logic       tick,
  input  logic [7:0] target,
  output logic [7:0] current,
  output logic       at_target
);

  localparam logic [8:0] STEP_9 = 9'(STEP);
  localparam logic [7:0] STEP_8 = 8'(STEP);

  logic [7:0] cur_r;
  logic [7:0] cur_nxt_s;
  logic [8:0] diff_s;
  logic [8:0] mag_s;

  // Next channel value: snap to target when within one step, else move one step.
  always_comb begin
    diff_s = {1'b0, target} - {1'b0, cur_r};
    mag_s  = diff_s[8] ? (9'd0 - diff_s) : diff_s;
    if (mag_s <= STEP_9) begin
      cur_nxt_s = target;
    end else if (diff_s[8]) begin
      cur_nxt_s = cur_r - STEP_8;
    end else begin
      cur_nxt_s = cur_r + STEP_8;
    end
  end

  // Channel register, advanced only on fade ticks.
  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) begin
      cur_r <= 8'd0;
    end else if (tick) begin
      cur_r <= cur_nxt_s;
    end else begin
      cur_r <= cur_r;
    end
  end

  assign current   = cur_r;
  assign at_target = (cur_r == target);

endmodule

// File: rtl/sk6805_color_ctrl.sv
// SK6805 colour source: fades LED1 to a per-class colour, holds, fades back;
// LED2 shows status. Define SK6805_BLINK_EN to blink LED1 while holding.
module sk6805_color_ctrl
  import sk6805_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned STEP       = 4,
  parameter int unsigned HOLD_TICKS = 2000,
  parameter int unsigned BLINK_HALF = 250
) (
  input  logic       clk_10MHz,
  input  logic       Rst,
  input  logic [2:0] Class_In,
  input  logic       Class_Valid,
  output logic [7:0] R_Out1,
  output logic [7:0] G_Out1,
  output logic [7:0] B_Out1,
  output logic [7:0] R_Out2,
  output logic [7:0] G_Out2,
  output logic [7:0] B_Out2,
  output logic       Busy
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  // Hold and blink counters share one width so either can be the longer phase.
  localparam int unsigned CNT_MAX = (HOLD_TICKS > BLINK_HALF) ? HOLD_TICKS : BLINK_HALF;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);

  state_t               state_r, state_nxt_s;
  logic [PRESC_W-1:0]   presc_r;
  logic [CNT_W-1:0]     hold_cnt_r;
  logic [23:0]          target_r, target_nxt_s;
  logic [23:0]          status_r, status_nxt_s;
  logic                 busy_r;
  logic                 tick_s, all_at_s, hold_done_s, led1_off_s;
  logic [7:0]           cur_r_s, cur_g_s, cur_b_s;
  logic                 at_r_s, at_g_s, at_b_s;

  assign tick_s      = (presc_r == PRESC_LAST);
  assign all_at_s    = at_r_s & at_g_s & at_b_s;
  assign hold_done_s = (state_r == HOLD) && tick_s && (hold_cnt_r == HOLD_LAST);

  // Free-running tick prescaler; never resynchronised to the class strobe.
  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1'b1);
    end
  end

  // Hold tick counter, held at zero outside HOLD.
  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) begin
      hold_cnt_r <= '0;
    end else if (state_r != HOLD) begin
      hold_cnt_r <= '0;
    end else if (tick_s) begin
      hold_cnt_r <= hold_cnt_r + CNT_W'(1'b1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Next state and target; a class strobe overrides hold expiry and return-done.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    if (Class_Valid) begin
      target_nxt_s = class_rgb(Class_In);
      if (Class_In != 3'd0) begin
        state_nxt_s = FADE;
      end else if (state_r == IDLE) begin
        state_nxt_s = IDLE;
      end else begin
        state_nxt_s = RETURN;
      end
    end else begin
      case (state_r)
        IDLE:   state_nxt_s = IDLE;
        FADE:   state_nxt_s = all_at_s ? HOLD : FADE;
        HOLD: begin
          if (hold_done_s) begin
            state_nxt_s  = RETURN;
            target_nxt_s = 24'h00_00_00;
          end else begin
            state_nxt_s  = HOLD;
          end
        end
        RETURN: state_nxt_s = all_at_s ? IDLE : RETURN;
        default: begin
          state_nxt_s  = IDLE;
          target_nxt_s = 24'h00_00_00;
        end
      endcase
    end
  end

  // Status colour for the state being entered.
  always_comb begin
    case (state_nxt_s)
      IDLE:        status_nxt_s = STATUS_OFF;
      FADE, RETURN: status_nxt_s = STATUS_BUSY;
      HOLD:        status_nxt_s = STATUS_HOLD;
      default:     status_nxt_s = STATUS_OFF;
    endcase
  end

  // State, target and the state-derived outputs update together.
  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) begin
      state_r  <= IDLE;
      target_r <= 24'h00_00_00;
      status_r <= STATUS_OFF;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      target_r <= target_nxt_s;
      status_r <= status_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
    end
  end

  sk6805_fade_chan #(.STEP(STEP)) u_chan_r (
    .clk_10MHz (clk_10MHz),
    .Rst       (Rst),
    .tick      (tick_s),
    .target    (target_r[23:16]),
    .current   (cur_r_s),
    .at_target (at_r_s)
  );

  sk6805_fade_chan #(.STEP(STEP)) u_chan_g (
    .clk_10MHz (clk_10MHz),
    .Rst       (Rst),
    .tick      (tick_s),
    .target    (target_r[15:8]),
    .current   (cur_g_s),
    .at_target (at_g_s)
  );

  sk6805_fade_chan #(.STEP(STEP)) u_chan_b (
    .clk_10MHz (clk_10MHz),
    .Rst       (Rst),
    .tick      (tick_s),
    .target    (target_r[7:0]),
    .current   (cur_b_s),
    .at_target (at_b_s)
  );

`ifdef SK6805_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] blink_cnt_r;
  logic             blink_ph_r;

  // Blink phase counter; restarts in the "on" phase each time HOLD is entered.
  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (state_r != HOLD) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (tick_s && (blink_cnt_r == BLINK_LAST)) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= ~blink_ph_r;
    end else if (tick_s) begin
      blink_cnt_r <= blink_cnt_r + CNT_W'(1'b1);
      blink_ph_r  <= blink_ph_r;
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_ph_r  <= blink_ph_r;
    end
  end

  assign led1_off_s = (state_r == HOLD) && blink_ph_r;
`else
  assign led1_off_s = 1'b0;
`endif

  assign R_Out1 = led1_off_s ? 8'd0 : cur_r_s;
  assign G_Out1 = led1_off_s ? 8'd0 : cur_g_s;
  assign B_Out1 = led1_off_s ? 8'd0 : cur_b_s;
  assign {R_Out2, G_Out2, B_Out2} = status_r;
  assign Busy = busy_r;

endmodule
